alarm_bank: RTL

Multi-channel alarm unit for the board clock: holds `NUM_ALARMS` independent hh:mm alarm settings, edits them from the three front-panel buttons in the alarm-set mode, and drives the piezo when an enabled alarm's time is reached. It extends the single-alarm block with the following features:

- edge-detected button editing with correct 23→0 and 59→0 wrap;
- per-channel enables;
- a ringing state machine with snooze and stop;
- automatic ring timeout.

It sits beside the timekeeping counter and feeds the display mux and the piezo pin.

---
 rtl/alarm_pkg.sv | 16 +
 rtl/alarm_time_add.sv | 33 +++
 rtl/alarm_bank.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/alarm_pkg.sv
// Shared types and constants for the multi-channel alarm unit and the
// hh:mm arithmetic used beside the timekeeping counter.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } ring_state_e;

  localparam int HOURS_PER_DAY = 24;
  localparam int MIN_PER_HOUR  = 60;
  localparam int RST_HOUR      = 7;
  localparam int RST_MIN       = 0;

endpackage

// File: rtl/alarm_time_add.sv
// Combinational hh:mm + N minutes with minute and day wrap; outputs are
// always in range even for out-of-range inputs.
module alarm_time_add (
  input  logic [5:0] hour,
  input  logic [5:0] min,
  input  logic [5:0] add_min,
  output logic [5:0] sum_hour,
  output logic [5:0] sum_min
);
  import alarm_pkg::*;

  logic [6:0] m_sum;
  logic [6:0] h_sum;

  always_comb begin
    m_sum = {1'b0, min} + {1'b0, add_min};
    h_sum = {1'b0, hour};
    // Two passes cover the worst case 63+63 from out-of-range inputs.
    if (m_sum >= 7'(MIN_PER_HOUR)) begin
      m_sum = m_sum - 7'(MIN_PER_HOUR);
      h_sum = h_sum + 7'd1;
    end
    if (m_sum >= 7'(MIN_PER_HOUR)) begin
      m_sum = m_sum - 7'(MIN_PER_HOUR);
      h_sum = h_sum + 7'd1;
    end
    if (h_sum >= 7'(HOURS_PER_DAY)) h_sum = h_sum - 7'(HOURS_PER_DAY);
    if (h_sum >= 7'(HOURS_PER_DAY)) h_sum = 7'd0;
    sum_hour = h_sum[5:0];
    sum_min  = m_sum[5:0];
  end

endmodule

// File: rtl/alarm_bank.sv
// Multi-channel hh:mm alarm: front-panel editing, per-channel arming and a
// ringing FSM with snooze, stop and automatic ring timeout.
module alarm_bank #(
  parameter int          NUM_ALARMS = 2,
  parameter int          SNOOZE_MIN = 5,
  parameter int          MAX_SNOOZE = 3,
  parameter int          RING_MIN   = 1,
  parameter logic [3:0]  EDIT_STATE = 4'd2,
  localparam int         SW         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            state,
  input  logic                  b1,
  input  logic                  b2,
  input  logic                  b3,
  input  logic [NUM_ALARMS-1:0] alarm_en,
  input  logic                  snooze,
  input  logic                  stop,
  input  logic [5:0]            hour,
  input  logic [5:0]            min,
  output logic [SW-1:0]         sel,
  output logic [5:0]            ahour,
  output logic [5:0]            amin,
  output logic                  piezo,
  output logic [SW-1:0]         ring_ch,
  output logic                  snoozed
);
  import alarm_pkg::*;

  localparam logic [7:0]    MAX_SN   = 8'(MAX_SNOOZE);
  localparam logic [3:0]    RING_LIM = 4'(RING_MIN);
  localparam logic [SW-1:0] LAST_CH  = SW'(NUM_ALARMS - 1);

  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] last);
    return (v >= last) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic en);
    return (en && v != 4'hF) ? v + 4'd1 : v;
  endfunction

  logic [5:0]            hr_q [NUM_ALARMS];
  logic [5:0]            mn_q [NUM_ALARMS];
  logic [SW-1:0]         sel_q, ring_ch_q, win_ch;
  logic                  b1_p1, b2_p1, b3_p1, snz_p1, stop_p1;
  logic                  b1_e, b2_e, b3_e, snz_e, stop_e, edit;
  logic [NUM_ALARMS-1:0] match, match_p1, trig;
  logic [5:0]            min_p1;
  logic                  min_chg, en_ring;
  ring_state_e           st_q, st_nxt;
  logic                  ld_ring, ld_snz, rering;
  logic [7:0]            snz_cnt;
  logic [3:0]            min_cnt, min_cnt_nxt;
  logic [5:0]            tgt_h, tgt_m, add_h, add_m;
  logic                  piezo_q, snoozed_q;

  alarm_time_add u_add (
    .hour     (hour),
    .min      (min),
    .add_min  (6'(SNOOZE_MIN)),
    .sum_hour (add_h),
    .sum_min  (add_m)
  );

  assign edit   = (state == EDIT_STATE);
  assign b1_e   = b1 & ~b1_p1;
  assign b2_e   = b2 & ~b2_p1;
  assign b3_e   = b3 & ~b3_p1;
  assign snz_e  = snooze & ~snz_p1;
  assign stop_e = stop & ~stop_p1;

  // Match and trigger: triggers masked in edit mode while history keeps tracking
  always_comb begin
    match  = '0;
    win_ch = '0;
    for (int i = 0; i < NUM_ALARMS; i++)
      match[i] = alarm_en[i] && (hour == hr_q[i]) && (min == mn_q[i]);
    trig = edit ? '0 : (match & ~match_p1);
    for (int i = NUM_ALARMS - 1; i >= 0; i--)
      if (trig[i]) win_ch = SW'(i);
  end

  always_comb begin
    st_nxt      = st_q;
    ld_ring     = 1'b0;
    ld_snz      = 1'b0;
    rering      = 1'b0;
    min_chg     = (min != min_p1);
    min_cnt_nxt = sat_inc(min_cnt, min_chg);
    en_ring     = alarm_en[ring_ch_q];
    case (st_q)
      IDLE: begin
        if (|trig) begin
          st_nxt  = RINGING;
          ld_ring = 1'b1;
        end
      end
      RINGING: begin
        if (stop_e || !en_ring || (min_cnt_nxt >= RING_LIM)) begin
          st_nxt = IDLE;
        end else if (snz_e && (snz_cnt < MAX_SN)) begin
          st_nxt = SNOOZED;
          ld_snz = 1'b1;
        end
      end
      SNOOZED: begin
        if (stop_e || !en_ring) begin
          st_nxt = IDLE;
        end else if ((hour == tgt_h) && (min == tgt_m)) begin
          st_nxt = RINGING;
          rering = 1'b1;
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  // Stage p1: control state, input history and channel settings
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q      <= IDLE;
      piezo_q   <= 1'b0;
      snoozed_q <= 1'b0;
      sel_q     <= '0;
      ring_ch_q <= '0;
      snz_cnt   <= '0;
      min_cnt   <= '0;
      min_p1    <= '0;
      match_p1  <= '0;
      b1_p1     <= 1'b0;
      b2_p1     <= 1'b0;
      b3_p1     <= 1'b0;
      snz_p1    <= 1'b0;
      stop_p1   <= 1'b0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        hr_q[i] <= 6'(RST_HOUR);
        mn_q[i] <= 6'(RST_MIN);
      end
    end else begin
      st_q      <= st_nxt;
      piezo_q   <= (st_nxt == RINGING);
      snoozed_q <= (st_nxt == SNOOZED);
      min_p1    <= min;
      match_p1  <= match;
      b1_p1     <= b1;
      b2_p1     <= b2;
      b3_p1     <= b3;
      snz_p1    <= snooze;
      stop_p1   <= stop;
      if (ld_ring) begin
        ring_ch_q <= win_ch;
        snz_cnt   <= '0;
      end else if (ld_snz) begin
        snz_cnt   <= snz_cnt + 8'd1;
      end
      min_cnt <= (ld_ring || rering) ? 4'd0 : min_cnt_nxt;
      if (edit) begin
        if (b1_e)
          hr_q[sel_q] <= wrap_inc(hr_q[sel_q], 6'(HOURS_PER_DAY - 1));
        else if (b2_e)
          mn_q[sel_q] <= wrap_inc(mn_q[sel_q], 6'(MIN_PER_HOUR - 1));
        else if (b3_e)
          sel_q <= (sel_q == LAST_CH) ? '0 : sel_q + SW'(1);
      end
    end
  end

  // Snooze target only matters once loaded, so it carries no reset
  always_ff @(posedge clk) begin
    if (ld_snz) begin
      tgt_h <= add_h;
      tgt_m <= add_m;
    end
  end

  assign sel     = sel_q;
  assign ring_ch = ring_ch_q;
  assign ahour   = hr_q[sel_q];
  assign amin    = mn_q[sel_q];
  assign piezo   = piezo_q;
  assign snoozed = snoozed_q;

endmodule
